// File: rtl/pokey_kbd_scan.sv
// pokey_kbd_scan - POKEY keyboard scan sequencer: key address stepping, debounce FSM, KBCODE/SKSTAT outputs.
// Rev 1.0. Optional second-key detect enabled by defining POKEY_KBD_MULTIKEY_EN.
`default_nettype none

module pokey_kbd_scan #(
  parameter int SCAN_DIV = 114,
  parameter int KEY_W    = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enn,
  input  logic [7:0]       skctls,
  input  logic             init,
  input  logic             kr1_n,
  input  logic             kr2_n,
  output logic [KEY_W-1:0] k,
  output logic [KEY_W+1:0] kbcode,
  output logic             kbcode_wr,
  output logic             break_wr,
  output logic             key_down,
  output logic             shift_down,
  output logic             multi_key
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]    c_PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [KEY_W-1:0] c_K_CTRL   = KEY_W'(6'h00);
  localparam logic [KEY_W-1:0] c_K_SHIFT  = KEY_W'(6'h10);
  localparam logic [KEY_W-1:0] c_K_BREAK  = KEY_W'(6'h30);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_pre;
  logic [KEY_W-1:0] r_k;
  logic [KEY_W-1:0] r_cmp;
  logic [KEY_W+1:0] r_kbcode;
  logic             r_kbcode_wr;
  logic             r_break_wr;
  logic             r_ctrl;
  logic             r_shift;
  logic             r_brk_prev;
  logic             r_kr1_meta, r_kr1_sync;
  logic             r_kr2_meta, r_kr2_sync;

  logic w_kr1_dn, w_kr2_dn, w_run, w_pre_last, w_step, w_at_cmp;
  logic w_unused;

  assign w_kr1_dn   = ~r_kr1_sync;
  assign w_kr2_dn   = ~r_kr2_sync;
  assign w_run      = skctls[1];
  assign w_pre_last = (r_pre == c_PRE_LAST);
  assign w_step     = w_run & enn & w_pre_last;
  assign w_at_cmp   = (r_k == r_cmp);
  assign w_unused   = ^skctls[7:2];

  // Return lines are asynchronous to clk; idle level (released) is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kr1_meta <= 1'b1;
      r_kr1_sync <= 1'b1;
      r_kr2_meta <= 1'b1;
      r_kr2_sync <= 1'b1;
    end else begin
      r_kr1_meta <= kr1_n;
      r_kr1_sync <= r_kr1_meta;
      r_kr2_meta <= kr2_n;
      r_kr2_sync <= r_kr2_meta;
    end
  end

`ifdef POKEY_KBD_MULTIKEY_EN
  logic r_multi;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_k         <= '0;
      r_cmp       <= '0;
      r_kbcode    <= '0;
      r_kbcode_wr <= 1'b0;
      r_break_wr  <= 1'b0;
      r_ctrl      <= 1'b0;
      r_shift     <= 1'b0;
      r_brk_prev  <= 1'b0;
`ifdef POKEY_KBD_MULTIKEY_EN
      r_multi     <= 1'b0;
`endif
    end else if (init) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_k         <= '0;
      r_cmp       <= '0;
      r_kbcode    <= '0;
      r_kbcode_wr <= 1'b0;
      r_break_wr  <= 1'b0;
      r_ctrl      <= 1'b0;
      r_shift     <= 1'b0;
      r_brk_prev  <= 1'b0;
`ifdef POKEY_KBD_MULTIKEY_EN
      r_multi     <= 1'b0;
`endif
    end else begin
      r_kbcode_wr <= 1'b0;
      r_break_wr  <= 1'b0;
      if (w_run && enn) begin
        r_pre <= w_pre_last ? '0 : r_pre + PW'(1);
      end
      if (w_step) begin
        r_k <= r_k + KEY_W'(1);
        if (r_k == c_K_CTRL)  r_ctrl  <= w_kr2_dn;
        if (r_k == c_K_SHIFT) r_shift <= w_kr2_dn;
        // BREAK is edge-detected against the previous scan's sample.
        if (r_k == c_K_BREAK) begin
          r_brk_prev <= w_kr2_dn;
          r_break_wr <= w_kr2_dn & ~r_brk_prev;
        end
        case (r_state)
          S_IDLE: begin
            if (w_kr1_dn) begin
              r_cmp <= r_k;
              if (skctls[0]) begin
                r_state <= S_PENDING;
              end else begin
                r_state     <= S_HELD;
                r_kbcode    <= {r_ctrl, r_shift, r_k};
                r_kbcode_wr <= 1'b1;
              end
            end
          end
          S_PENDING: begin
            if (w_at_cmp) begin
              if (w_kr1_dn) begin
                r_state     <= S_HELD;
                r_kbcode    <= {r_ctrl, r_shift, r_cmp};
                r_kbcode_wr <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_HELD: begin
            if (w_at_cmp && !w_kr1_dn) begin
              r_state <= skctls[0] ? S_RELEASE : S_IDLE;
            end
          end
          S_RELEASE: begin
            if (w_at_cmp) begin
              r_state <= w_kr1_dn ? S_HELD : S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
`ifdef POKEY_KBD_MULTIKEY_EN
        // Set and clear happen at different k (k!=cmp vs k==cmp), so they never collide.
        if (r_state == S_HELD || r_state == S_RELEASE) begin
          if (!w_at_cmp && w_kr1_dn) begin
            r_multi <= 1'b1;
          end else if (w_at_cmp && !w_kr1_dn && (r_state == S_RELEASE || !skctls[0])) begin
            r_multi <= 1'b0;
          end
        end
`endif
      end
    end
  end

  assign k          = r_k;
  assign kbcode     = r_kbcode;
  assign kbcode_wr  = r_kbcode_wr;
  assign break_wr   = r_break_wr;
  assign key_down   = (r_state == S_HELD) || (r_state == S_RELEASE);
  assign shift_down = r_shift;
`ifdef POKEY_KBD_MULTIKEY_EN
  assign multi_key  = r_multi;
`else
  assign multi_key  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pokey_kbd_scan.sv
// tb_pokey_kbd_scan - directed self-checking bench for pokey_kbd_scan with a simple key-matrix model.
// Rev 1.0
`default_nettype none

module tb_pokey_kbd_scan;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enn;
  logic [7:0] skctls;
  logic       init;
  logic       kr1_n;
  logic       kr2_n;
  logic [5:0] k;
  logic [7:0] kbcode;
  logic       kbcode_wr;
  logic       break_wr;
  logic       key_down;
  logic       shift_down;
  logic       multi_key;

`ifdef POKEY_KBD_MULTIKEY_EN
  localparam logic MK_EXP = 1'b1;
`else
  localparam logic MK_EXP = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_wr     = 0;
  int n_brk    = 0;

  logic       key_en   = 1'b0;
  logic       key2_en  = 1'b0;
  logic       ctrl_on  = 1'b0;
  logic       shift_on = 1'b0;
  logic       brk_on   = 1'b0;
  logic [5:0] key_addr  = 6'h00;
  logic [5:0] key2_addr = 6'h20;

  pokey_kbd_scan dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enn       (enn),
    .skctls    (skctls),
    .init      (init),
    .kr1_n     (kr1_n),
    .kr2_n     (kr2_n),
    .k         (k),
    .kbcode    (kbcode),
    .kbcode_wr (kbcode_wr),
    .break_wr  (break_wr),
    .key_down  (key_down),
    .shift_down(shift_down),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  // Key matrix: a return line goes low while its key's address is on k.
  assign kr1_n = !((key_en && k == key_addr) || (key2_en && k == key2_addr));
  assign kr2_n = !((ctrl_on && k == 6'h00) || (shift_on && k == 6'h10) || (brk_on && k == 6'h30));

  always @(negedge clk) begin
    if (kbcode_wr) n_wr++;
    if (break_wr)  n_brk++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for k to reach kv (bounded), then settle 1 time unit past the negedge.
  task automatic wait_k(input logic [5:0] kv);
    int n = 0;
    @(negedge clk);
    while (k !== kv && n < 8000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("wait_k", {26'd0, k}, {26'd0, kv});
  endtask

  initial begin
    reset_n = 1'b0;
    skctls  = 8'h00;
    init    = 1'b1;
    enn     = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_k",         k,          6'h00);
    check("rst_kbcode",    kbcode,     8'h00);
    check("rst_kbcode_wr", kbcode_wr,  1'b0);
    check("rst_break_wr",  break_wr,   1'b0);
    check("rst_key_down",  key_down,   1'b0);
    check("rst_shift",     shift_down, 1'b0);
    check("rst_multi",     multi_key,  1'b0);

    // Free-running scan, no keys
    skctls = 8'h03;
    init   = 1'b0;
    enn    = 1'b1;
    repeat (113) @(posedge clk);
    #1 check("pre_113_k", k, 6'h00);
    @(posedge clk);
    #1 check("pre_114_k", k, 6'h01);
    repeat (7181) @(posedge clk);
    #1 check("pre_7295_k", k, 6'h3F);
    @(posedge clk);
    #1 check("wrap_k", k, 6'h00);
    check("nokey_wr_cnt", n_wr, 0);

    // Debounced key at 0x15 with shift, BREAK held for three scans
    key_addr = 6'h15;
    key_en   = 1'b1;
    shift_on = 1'b1;
    brk_on   = 1'b1;
    wait_k(6'h16);
    check("s1_shift",    shift_down, 1'b1);
    check("s1_key_down", key_down,   1'b0);
    check("s1_wr_cnt",   n_wr,       0);
    wait_k(6'h31);
    check("s1_break_wr", break_wr, 1'b1);
    check("s1_brk_cnt",  n_brk,    1);
    wait_k(6'h16);
    check("s2_kbcode_wr", kbcode_wr, 1'b1);
    check("s2_kbcode",    kbcode,    8'h55);
    check("s2_key_down",  key_down,  1'b1);
    check("s2_wr_cnt",    n_wr,      1);
    wait_k(6'h31);
    check("s2_break_wr", break_wr, 1'b0);
    check("s2_brk_cnt",  n_brk,    1);
    key_en = 1'b0;
    wait_k(6'h16);
    check("s3_bounce_key_down", key_down,  1'b1);
    check("s3_bounce_wr",       kbcode_wr, 1'b0);
    key_en = 1'b1;
    wait_k(6'h31);
    check("s3_brk_cnt", n_brk, 1);
    brk_on = 1'b0;
    wait_k(6'h16);
    check("s4_key_down", key_down, 1'b1);
    check("s4_wr_cnt",   n_wr,     1);
    check("s4_kbcode",   kbcode,   8'h55);

    // init while key is held
    @(negedge clk);
    skctls   = 8'h00;
    init     = 1'b1;
    key_en   = 1'b0;
    shift_on = 1'b0;
    ctrl_on  = 1'b1;
    @(posedge clk);
    #1;
    check("init_k",        k,          6'h00);
    check("init_key_down", key_down,   1'b0);
    check("init_kbcode",   kbcode,     8'h00);
    check("init_shift",    shift_down, 1'b0);
    repeat (3) @(negedge clk);
    skctls = 8'h03;
    init   = 1'b0;
    repeat (113) @(posedge clk);
    #1 check("resume_113_k", k, 6'h00);
    @(posedge clk);
    #1 check("resume_114_k", k, 6'h01);

    // No debounce, key at 0x0A with ctrl latched
    skctls   = 8'h02;
    key_addr = 6'h0A;
    key_en   = 1'b1;
    wait_k(6'h0B);
    check("nd_kbcode_wr", kbcode_wr, 1'b1);
    check("nd_kbcode",    kbcode,    8'h8A);
    check("nd_key_down",  key_down,  1'b1);
    check("nd_multi0",    multi_key, 1'b0);
    skctls = 8'h01;
    repeat (300) @(negedge clk);
    #1;
    check("freeze_k",        k,        6'h0B);
    check("freeze_key_down", key_down, 1'b1);
    check("freeze_wr_cnt",   n_wr,     2);
    skctls  = 8'h02;
    key2_en = 1'b1;
    wait_k(6'h21);
    check("two_key_multi",    multi_key, MK_EXP);
    check("two_key_key_down", key_down,  1'b1);
    key_en  = 1'b0;
    key2_en = 1'b0;
    wait_k(6'h0B);
    check("nd_rel_key_down", key_down,  1'b0);
    check("nd_rel_wr",       kbcode_wr, 1'b0);
    check("nd_rel_wr_cnt",   n_wr,      2);
    check("nd_rel_multi",    multi_key, 1'b0);
    check("final_brk_cnt",   n_brk,     1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pokey_kbd_scan.md
Name: pokey_kbd_scan

Overview:
Keyboard scan sequencer for the POKEY core, configured by the SKCTLS register outputs (skctls bus and init).
- Steps a 6-bit key address through the matrix at a divided machine-clock rate.
- Samples the key-return lines and runs a debounce/compare state machine.
- Delivers KBCODE, a keycode-ready pulse for IRQ logic, and SKSTAT key/shift status.

Parameters:
SCAN_DIV, 114, number of enn strobes per key-address step (1 scan line).
KEY_W, 6, width of key address counter (fixed 6 for POKEY; must not exceed 6).

Ports:
clk  input  1  system clock (50 MHz).
reset_n  input  1  asynchronous active-low reset.
enn  input  1  one-clk 1.79 MHz machine-cycle strobe (negative-edge enable).
skctls  input  8  SKCTLS register value; bit0 debounce enable, bit1 scan enable.
init  input  1  SKCTLS init (skctls[1:0]==00); synchronous clear of scanner.
kr1_n  input  1  key return for addressed key, active low, asynchronous.
kr2_n  input  1  control/shift/break return, active low, asynchronous.
k  output  6  current key scan address to matrix.
kbcode  output  8  {ctrl, shift, key[5:0]} of last accepted key.
kbcode_wr  output  1  one-clk pulse when kbcode updated.
break_wr  output  1  one-clk pulse on BREAK press.
key_down  output  1  high while accepted key is held.
shift_down  output  1  latched shift status.
multi_key  output  1  second-key flag (optional feature; else 0).

Behaviour:
- Async reset, and sync clear while init=1 (init wins over any coincident event):
  - k=0, prescaler=0, FSM=IDLE, kbcode=0, ctrl/shift latches=0.
  - All pulses 0; multi_key=0.
- kr1_n and kr2_n pass through 2-flop synchronizers on clk; all sampling uses the synchronized values.
- skctls[1]=0 with init=0: prescaler, k and FSM frozen, no pulses generated; outputs hold.
- Prescaler counts enn strobes 0..SCAN_DIV-1. A "step" is the clk cycle where enn=1 and count==SCAN_DIV-1.
- On a step:
  - Sample kr1/kr2 at the current k, then k<=k+1, wrapping 63->0.
  - Full scan = 64*SCAN_DIV enn strobes.
- kr2 decoding on a step:
  - k==6'h00 loads ctrl latch.
  - k==6'h10 loads shift latch.
  - k==6'h30: high->low transition vs. previous sample at 6'h30 pulses break_wr the cycle after the step.
- FSM, evaluated only on steps; cmp = 6-bit compare latch:
  - IDLE: kr1 low -> cmp<=k. If skctls[0]=0, accept and go HELD; else go PENDING.
  - PENDING: at k==cmp: kr1 low -> accept, go HELD; kr1 high -> IDLE. Other k ignored.
  - HELD: at k==cmp with kr1 high -> RELEASE if skctls[0]=1, else IDLE.
  - RELEASE: at k==cmp: kr1 high -> IDLE; kr1 low -> HELD with no new accept (bounce).
- Accept: kbcode<={ctrl, shift, cmp}; kbcode_wr pulses exactly one clk, the cycle after the step.
- key_down = FSM in HELD or RELEASE.
- shift_down = shift latch.
- A skctls[0] change mid-operation takes effect at the next step; current state is retained.

Optional Feature:
POKEY_KBD_MULTIKEY_EN:
- Defined: in HELD or RELEASE, a step with kr1 low at k!=cmp sets multi_key. multi_key clears on entry to IDLE, reset or init.
- Undefined: multi_key tied 0 and no extra logic.

Test Plan:
- Reset, then skctls=8'h03 with no keys -> k advances by 1 every 114 enn strobes and wraps 63->0 after 7296 strobes; no kbcode_wr.
- skctls=8'h03, kr1_n low only when k==6'h15, shift low at k==6'h10 -> exactly one kbcode_wr after the second scan; kbcode=8'h55; key_down=1.
- skctls=8'h02 (no debounce), key at k==6'h0A -> kbcode_wr on the first scan; release -> key_down=0 at the next k==6'h0A step.
- Debounced key held, bounced high for one scan then low again -> RELEASE->HELD; no second kbcode_wr; key_down stays 1.
- kr2_n low at k==6'h30 for 3 scans -> exactly one break_wr pulse.
- Key held, then skctls=8'h00 -> k=0, key_down=0, FSM IDLE; scanning resumes from k=0 after skctls=8'h03.
- With POKEY_KBD_MULTIKEY_EN: keys at 6'h15 and 6'h20 both low -> multi_key=1; release both -> multi_key=0.
